// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter applying one JK command per two cycles to a JK flip-flop bank
module jk_bank_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int IDX_W   = $clog2(WIDTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*IDX_W-1:0] req_idx,
   input  logic [NUM_REQ*2-1:0]     req_jk,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     done,
   output logic                     err,
   output logic [WIDTH-1:0]         q,
   output logic                     busy
);
   localparam int RW = $clog2(NUM_REQ);
   localparam logic [IDX_W:0] W_LIM = (IDX_W+1)'(WIDTH);
   typedef enum logic {IDLE, APPLY} state_t;
   state_t          state, state_nx;
   logic [RW-1:0]   rr_ptr, win, win_r;
   logic [IDX_W-1:0] idx_r;
   logic [1:0]      jk_r;
   logic            found, in_range;
   // first pending requester at or after rr_ptr, wrapping around
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
            found = 1'b1;
            win   = RW'((int'(rr_ptr) + k) % NUM_REQ);
         end
      end
   end
   // APPLY always lasts one cycle; IDLE leaves only when someone requests
   always_comb state_nx = (state == APPLY) ? IDLE : (|req ? APPLY : IDLE);
   // state register
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end
   // capture the winner's command in IDLE, apply it and advance the pointer when APPLY closes
   always_ff @(posedge clk) begin
      if (!rst) begin
         q      <= '0;
         rr_ptr <= '0;
         win_r  <= '0;
         idx_r  <= '0;
         jk_r   <= '0;
      end else begin
         if (state == IDLE && |req) begin
            win_r <= win;
            idx_r <= req_idx[int'(win)*IDX_W +: IDX_W];
            jk_r  <= req_jk[int'(win)*2 +: 2];
         end
         if (state == APPLY) begin
            rr_ptr <= (int'(win_r) == NUM_REQ-1) ? '0 : win_r + 1'b1;
            if (in_range) q[idx_r] <= (jk_r[1] & ~q[idx_r]) | (~jk_r[0] & q[idx_r]);
         end
      end
   end
   assign in_range = {1'b0, idx_r} < W_LIM;
   assign busy     = state != IDLE;
   assign done     = state == APPLY;
   assign err      = done && !in_range;
   assign gnt      = done ? NUM_REQ'(1) << win_r : '0;
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: directed scoreboard bench for jk_bank_arbiter (NUM_REQ=4, WIDTH=6)
module tb_jk_bank_arbiter;
   localparam int NR = 4;
   localparam int W  = 6;
   localparam int IW = 3;
   typedef struct packed {
      logic [NR-1:0] g;
      logic          e;
      logic [W-1:0]  q;
   } exp_t;
   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NR-1:0] req = '0;
   logic [NR*IW-1:0] req_idx = '0;
   logic [NR*2-1:0]  req_jk = '0;
   logic [NR-1:0] gnt;
   logic          done, err, busy;
   logic [W-1:0]  q;
   exp_t          sb[$];
   int            checks = 0;
   int            errors = 0;
   jk_bank_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .req(req), .req_idx(req_idx), .req_jk(req_jk),
      .gnt(gnt), .done(done), .err(err), .q(q), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask
   // wait (bounded) for gnt[r]; returns cycles taken, timeout counted as failure
   task automatic wait_gnt(input int r, output int n);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n++;
         if (gnt[r]) break;
      end
      if (!gnt[r]) chk("gnt_timeout", 32'(gnt), 32'(1 << r));
   endtask
   task automatic issue(input int r, input int idx, input logic [1:0] jk,
                        input logic [NR-1:0] eg, input logic ee, input logic [W-1:0] eq);
      int n;
      req_idx[r*IW +: IW] = IW'(idx);
      req_jk[r*2 +: 2]    = jk;
      sb.push_back('{g: eg, e: ee, q: eq});
      req[r] = 1'b1;
      wait_gnt(r, n);
      chk("latency", 32'(n), 32'd1);
      req[r] = 1'b0;
      @(negedge clk);
   endtask
   task automatic reset_pulse();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask
   // monitor: every done pulse pops one expectation, checks gnt/err/busy, then q after the closing edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'(gnt), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("gnt", 32'(gnt), 32'(e.g));
               chk("err", 32'(err), 32'(e.e));
               chk("busy_apply", 32'(busy), 32'd1);
               @(negedge clk);
               chk("q", 32'(q), 32'(e.q));
               chk("done_pulse", 32'(done), 32'd0);
            end
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end
   initial begin
      int cnt;
      repeat (2) @(negedge clk);
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      // set, toggle twice, hold
      issue(0, 3, 2'b10, 4'b0001, 1'b0, 6'h08);
      issue(1, 3, 2'b11, 4'b0010, 1'b0, 6'h00);
      issue(1, 3, 2'b11, 4'b0010, 1'b0, 6'h08);
      issue(1, 2, 2'b00, 4'b0010, 1'b0, 6'h08);
      // all four held: strict rotation from pointer 0
      reset_pulse();
      chk("rst2_q", 32'(q), 32'd0);
      req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
      req_jk  = 8'b10101010;
      sb.push_back('{g: 4'b0001, e: 1'b0, q: 6'h01});
      sb.push_back('{g: 4'b0010, e: 1'b0, q: 6'h03});
      sb.push_back('{g: 4'b0100, e: 1'b0, q: 6'h07});
      sb.push_back('{g: 4'b1000, e: 1'b0, q: 6'h0F});
      sb.push_back('{g: 4'b0001, e: 1'b0, q: 6'h0F});
      req = 4'hF;
      cnt = 0;
      for (int n = 0; n < 40 && cnt < 5; n++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      req = '0;
      chk("rr_count", 32'(cnt), 32'd5);
      @(negedge clk);
      // out-of-range indices and the last valid one
      issue(2, 7, 2'b10, 4'b0100, 1'b1, 6'h0F);
      issue(2, 6, 2'b11, 4'b0100, 1'b1, 6'h0F);
      issue(2, 5, 2'b10, 4'b0100, 1'b0, 6'h2F);
      // pointer at 3: requester 3 beats 0
      req_idx[0 +: IW] = 3'd4;
      req_jk[0 +: 2]   = 2'b11;
      req_idx[9 +: IW] = 3'd4;
      req_jk[6 +: 2]   = 2'b10;
      sb.push_back('{g: 4'b1000, e: 1'b0, q: 6'h3F});
      sb.push_back('{g: 4'b0001, e: 1'b0, q: 6'h2F});
      req = 4'b1001;
      for (int n = 0; n < 20 && req != '0; n++) begin
         @(negedge clk);
         if (done) req = req & ~gnt;
      end
      chk("pair_served", 32'(req), 32'd0);
      @(negedge clk);
      // captured op is used even if inputs change during APPLY
      issue(0, 4, 2'b10, 4'b0001, 1'b0, 6'h3F);
      begin
         int n;
         req_idx[9 +: IW] = 3'd0;
         req_jk[6 +: 2]   = 2'b01;
         sb.push_back('{g: 4'b1000, e: 1'b0, q: 6'h3E});
         req[3] = 1'b1;
         wait_gnt(3, n);
         req_jk[6 +: 2]   = 2'b10;
         req_idx[9 +: IW] = 3'd5;
         req[3] = 1'b0;
         @(negedge clk);
      end
      // reset during APPLY discards the command
      begin
         int n;
         req_idx[0 +: IW] = 3'd1;
         req_jk[0 +: 2]   = 2'b10;
         sb.push_back('{g: 4'b0001, e: 1'b0, q: 6'h00});
         req[0] = 1'b1;
         wait_gnt(0, n);
         req[0] = 1'b0;
         rst = 1'b0;
         @(negedge clk);
         chk("apply_rst_gnt", 32'(gnt), 32'd0);
         chk("apply_rst_busy", 32'(busy), 32'd0);
         chk("apply_rst_err", 32'(err), 32'd0);
         rst = 1'b1;
         repeat (3) @(negedge clk);
         chk("apply_rst_q", 32'(q), 32'd0);
         chk("apply_rst_idle", 32'(busy), 32'd0);
      end
      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
